writeback_scheduler: RTL
========================

Name: writeback_scheduler

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: ALU results and memory-load results.
- Arbitrates round-robin and drives the register file's RegisterWrite/WriteRegister/WriteData through a one-cycle registered stage.
- Keeps a per-register pending-write scoreboard (Busy) that decode uses for hazard stalls.

Parameters:
- DataWidth, 32, width of write data.
- AddressWidth, 5, register index width; 2**AddressWidth registers.
- CountWidth, 16, width of the committed-write counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Hold  input  1  pipeline freeze; when 1 no request is accepted.
- AluValid  input  1  ALU writeback request.
- AluReady  output  1  ALU request accepted this cycle (combinational).
- AluRegister  input  AddressWidth  ALU destination register.
- AluData  input  DataWidth  ALU result.
- MemValid  input  1  load writeback request.
- MemReady  output  1  load request accepted this cycle (combinational).
- MemRegister  input  AddressWidth  load destination register.
- MemData  input  DataWidth  load data.
- IssueValid  input  1  an instruction with a destination register issues this cycle.
- IssueRegister  input  AddressWidth  destination of the issuing instruction.
- RegisterWrite  output  1  register file write enable (registered).
- WriteRegister  output  AddressWidth  register file write address (registered).
- WriteData  output  DataWidth  register file write data (registered).
- Busy  output  2**AddressWidth  scoreboard; bit r = 1 while a write to r is pending.
- WriteCount  output  CountWidth  number of register file writes committed since reset.

Behaviour:
- Reset (synchronous, active-high): RegisterWrite=0, WriteRegister=0, WriteData=0, Busy=0, WriteCount=0, LastGrant=Mem (so ALU wins the first tie). AluReady/MemReady are 0 while Reset=1.
- Grant (combinational):
  - Hold=1 or Reset=1: no grant.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not LastGrant.
  - AluReady = grant to ALU; MemReady = grant to Mem. At most one Ready is high in any cycle.
- Handshake:
  - A transfer occurs when Valid and Ready are both 1 at a rising edge.
  - Requesters must hold Valid, Register and Data stable until accepted.
  - Ready never depends on its own requester's Register or Data.
- LastGrant updates only on a transfer. It is unchanged in idle cycles and while Hold=1.
- Output stage, on every edge:
  - RegisterWrite <= transfer and (granted register != 0).
  - WriteRegister <= granted register; WriteData <= granted data, loaded on every transfer including transfers to register 0.
  - On no transfer, RegisterWrite <= 0 and WriteRegister/WriteData hold their values.
  - Latency is exactly one cycle: a request accepted at edge N writes the register file at edge N+1. Throughput is one write per cycle.
- Register 0: a transfer to register 0 completes the handshake but never asserts RegisterWrite and never increments WriteCount.
- Scoreboard (per bit r):
  - Set when IssueValid and IssueRegister==r (r != 0).
  - Cleared when a transfer to r is accepted.
  - Simultaneous set and clear of the same r: set wins, because a newer producer is pending.
  - Busy[0] is constantly 0.
  - Busy is a registered output reflecting state after the edge.
- WriteCount increments by 1 on each edge at which RegisterWrite is asserted into the output stage (nonzero transfer). It wraps modulo 2**CountWidth.
- Reset mid-operation:
  - A pending transfer at the reset edge is discarded: RegisterWrite=0 in the next cycle.
  - Scoreboard is cleared and LastGrant returns to Mem.
- Hold mid-request: Ready drops immediately, nothing is lost, and requesters keep Valid asserted.

Test Plan:
- Reset then idle 5 cycles: RegisterWrite=0, Busy=0, WriteCount=0, both Ready=0 throughout.
- ALU alone: AluValid=1, AluRegister=5, AluData=0xDEADBEEF at edge N -> AluReady=1 in cycle N; at edge N+1 RegisterWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; WriteCount=1.
- Both valid 4 consecutive cycles (ALU reg 3, Mem reg 7) -> grants ALU, Mem, ALU, Mem in order; RegisterWrite=1 every cycle; WriteCount=4.
- Mem transfer to register 0 with MemData=0x1234 -> MemReady=1, RegisterWrite stays 0, WriteCount unchanged.
- IssueValid on reg 9 -> Busy[9]=1. Then ALU writes reg 9 in the same cycle as a new issue to reg 9 -> Busy[9] remains 1. A later lone write to reg 9 -> Busy[9]=0.
- Hold=1 with both valid for 3 cycles -> no Ready, no writes. Assert Reset with a transfer in flight -> next cycle RegisterWrite=0, Busy=0, WriteCount=0, and the first tie after reset goes to ALU.

Source files
------------

// File: rtl/writeback_scheduler.sv
// Round-robin writeback arbiter sharing the register file write port between
// ALU and load results, with a registered write stage and pending-write scoreboard.
module writeback_scheduler #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 5,
  parameter int unsigned CountWidth   = 16
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         Hold,
  input  logic                         AluValid,
  output logic                         AluReady,
  input  logic [AddressWidth-1:0]      AluRegister,
  input  logic [DataWidth-1:0]         AluData,
  input  logic                         MemValid,
  output logic                         MemReady,
  input  logic [AddressWidth-1:0]      MemRegister,
  input  logic [DataWidth-1:0]         MemData,
  input  logic                         IssueValid,
  input  logic [AddressWidth-1:0]      IssueRegister,
  output logic                         RegisterWrite,
  output logic [AddressWidth-1:0]      WriteRegister,
  output logic [DataWidth-1:0]         WriteData,
  output logic [(2**AddressWidth)-1:0] Busy,
  output logic [CountWidth-1:0]        WriteCount
);

  localparam int unsigned NumRegs = 2 ** AddressWidth;

  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_MEM = 1'b1;

  logic [0:0]              last_grant_q, last_grant_d;
  logic                    reg_write_q, reg_write_d;
  logic [AddressWidth-1:0] wr_reg_q, wr_reg_d;
  logic [DataWidth-1:0]    wr_data_q, wr_data_d;
  logic [NumRegs-1:0]      busy_q, busy_d;
  logic [CountWidth-1:0]   count_q, count_d;

  logic                    grant_alu, grant_mem, xfer;
  logic [AddressWidth-1:0] sel_reg;
  logic [DataWidth-1:0]    sel_data;

  // Each grant looks only at the valids and LastGrant, never at the requester's payload.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!Reset && !Hold) begin
      grant_alu = AluValid && (!MemValid || (last_grant_q == GRANT_MEM));
      grant_mem = MemValid && (!AluValid || (last_grant_q == GRANT_ALU));
    end
  end

  assign AluReady = grant_alu;
  assign MemReady = grant_mem;
  assign xfer     = grant_alu || grant_mem;
  assign sel_reg  = grant_mem ? MemRegister : AluRegister;
  assign sel_data = grant_mem ? MemData     : AluData;

  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    count_d      = count_q;
    if (xfer) begin
      last_grant_d = grant_mem ? GRANT_MEM : GRANT_ALU;
      reg_write_d  = (sel_reg != '0);
      wr_reg_d     = sel_reg;
      wr_data_d    = sel_data;
      busy_d[sel_reg] = 1'b0;
      if (sel_reg != '0) begin
        count_d = count_q + 1'b1;
      end
    end
    // Issue is applied after the clear so a newer producer keeps the bit set.
    if (IssueValid) begin
      busy_d[IssueRegister] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_grant_q <= GRANT_MEM;
      reg_write_q  <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  assign RegisterWrite = reg_write_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign Busy          = busy_q;
  assign WriteCount    = count_q;

endmodule
